multicycle_control_fsm: RTL

Main control unit for the multicycle RV32I core: sequences fetch, decode, execute, memory and writeback over one shared ALU and one unified memory port. Drives every datapath select, including the 3-bit immediate-select code consumed by the immediate extender. It sits beside the datapath and stalls on a single memory ready handshake.

---
 rtl/rv_ctrl_pkg.sv | 99 +++++++++
 rtl/multicycle_control_fsm_if.sv | 33 +++
 rtl/alu_decoder.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes, datapath selects
// and helpers for immediate-type and branch-condition decode.
package rv_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t st_fetch    = 4'd0;
    localparam state_t st_decode   = 4'd1;
    localparam state_t st_memadr   = 4'd2;
    localparam state_t st_memread  = 4'd3;
    localparam state_t st_memwb    = 4'd4;
    localparam state_t st_memwrite = 4'd5;
    localparam state_t st_execr    = 4'd6;
    localparam state_t st_execi    = 4'd7;
    localparam state_t st_utype    = 4'd8;
    localparam state_t st_jalradr  = 4'd9;
    localparam state_t st_jump     = 4'd10;
    localparam state_t st_aluwb    = 4'd11;
    localparam state_t st_branch   = 4'd12;
    localparam state_t st_halt     = 4'd13;

    localparam logic [6:0] op_load   = 7'b0000011;
    localparam logic [6:0] op_store  = 7'b0100011;
    localparam logic [6:0] op_r      = 7'b0110011;
    localparam logic [6:0] op_i      = 7'b0010011;
    localparam logic [6:0] op_branch = 7'b1100011;
    localparam logic [6:0] op_jal    = 7'b1101111;
    localparam logic [6:0] op_jalr   = 7'b1100111;
    localparam logic [6:0] op_lui    = 7'b0110111;
    localparam logic [6:0] op_auipc  = 7'b0010111;

    localparam logic [1:0] aluop_add   = 2'b00;
    localparam logic [1:0] aluop_sub   = 2'b01;
    localparam logic [1:0] aluop_funct = 2'b10;

    localparam logic [3:0] alu_add  = 4'b0000;
    localparam logic [3:0] alu_sub  = 4'b0001;
    localparam logic [3:0] alu_and  = 4'b0010;
    localparam logic [3:0] alu_or   = 4'b0011;
    localparam logic [3:0] alu_xor  = 4'b0100;
    localparam logic [3:0] alu_slt  = 4'b0101;
    localparam logic [3:0] alu_sltu = 4'b0110;
    localparam logic [3:0] alu_sll  = 4'b0111;
    localparam logic [3:0] alu_srl  = 4'b1000;
    localparam logic [3:0] alu_sra  = 4'b1001;

    localparam logic [2:0] se_none  = 3'b000;
    localparam logic [2:0] se_i     = 3'b001;
    localparam logic [2:0] se_s     = 3'b010;
    localparam logic [2:0] se_b     = 3'b011;
    localparam logic [2:0] se_u     = 3'b100;
    localparam logic [2:0] se_j     = 3'b101;
    localparam logic [2:0] se_ishft = 3'b110;

    localparam logic [1:0] rs_aluout    = 2'b00;
    localparam logic [1:0] rs_data      = 2'b01;
    localparam logic [1:0] rs_aluresult = 2'b10;

    localparam logic [1:0] sa_pc    = 2'b00;
    localparam logic [1:0] sa_oldpc = 2'b01;
    localparam logic [1:0] sa_rs1   = 2'b10;
    localparam logic [1:0] sa_zero  = 2'b11;

    localparam logic [1:0] sb_rs2  = 2'b00;
    localparam logic [1:0] sb_imm  = 2'b01;
    localparam logic [1:0] sb_four = 2'b10;

    function automatic logic [2:0] src_ext_of(input logic [6:0] op, input logic [2:0] funct3);
        logic [2:0] se;
        se = se_none;
        case (op)
            op_i:              se = (funct3[1:0] == 2'b01) ? se_ishft : se_i;
            op_load, op_jalr:  se = se_i;
            op_store:          se = se_s;
            op_branch:         se = se_b;
            op_lui, op_auipc:  se = se_u;
            op_jal:            se = se_j;
            default:           se = se_none;
        endcase
        return se;
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_control_fsm_if;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       Zero;
    logic       Lt;
    logic       Ltu;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [2:0] SrcExt;
    logic       IllegalInstr;

    modport master (
        input  Op, Funct3, Funct7b5, Zero, Lt, Ltu, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, SrcExt, IllegalInstr
    );

    modport slave (
        output Op, Funct3, Funct7b5, Zero, Lt, Ltu, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, SrcExt, IllegalInstr
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction funct fields to the ALU operation code.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Op5,
    output logic [3:0] ALUControl
);

    always_comb begin
        ALUControl = alu_add;
        unique case (ALUOp)
            aluop_add: ALUControl = alu_add;
            aluop_sub: ALUControl = alu_sub;
            aluop_funct: begin
                unique case (Funct3)
                    // Bit 30 of an I-type word is immediate data, so only R-type may select sub.
                    3'b000: ALUControl = (Op5 && Funct7b5) ? alu_sub : alu_add;
                    3'b001: ALUControl = alu_sll;
                    3'b010: ALUControl = alu_slt;
                    3'b011: ALUControl = alu_sltu;
                    3'b100: ALUControl = alu_xor;
                    3'b101: ALUControl = Funct7b5 ? alu_sra : alu_srl;
                    3'b110: ALUControl = alu_or;
                    3'b111: ALUControl = alu_and;
                    default: ALUControl = alu_add;
                endcase
            end
            default: ALUControl = alu_add;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM. Optional macro RV_ILLEGAL_TRAP_EN sends illegal
// instructions to a HALT state left only by reset; otherwise they retire as a 2-cycle NOP.
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master ctrl
);

    state_t     state_q, state_d, illegal_dest;
    logic [1:0] alu_op;
    logic       pcwrite_raw, memwrite_raw, irwrite_raw, regwrite_raw;

`ifdef RV_ILLEGAL_TRAP_EN
    assign illegal_dest      = st_halt;
    assign ctrl.IllegalInstr = (state_q == st_halt);
`else
    assign illegal_dest      = st_fetch;
    assign ctrl.IllegalInstr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= st_fetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            st_fetch:    if (ctrl.MemReady) state_d = st_decode;
            st_decode: begin
                case (ctrl.Op)
                    op_load, op_store: state_d = st_memadr;
                    op_r:              state_d = st_execr;
                    op_i:              state_d = st_execi;
                    op_branch:         state_d = (ctrl.Funct3[2:1] == 2'b01) ? illegal_dest
                                                                             : st_branch;
                    op_jal:            state_d = st_jump;
                    op_jalr:           state_d = (ctrl.Funct3 == 3'b000) ? st_jalradr
                                                                         : illegal_dest;
                    op_lui, op_auipc:  state_d = st_utype;
                    default:           state_d = illegal_dest;
                endcase
            end
            st_memadr:   state_d = ctrl.Op[5] ? st_memwrite : st_memread;
            st_memread:  if (ctrl.MemReady) state_d = st_memwb;
            st_memwb:    state_d = st_fetch;
            st_memwrite: if (ctrl.MemReady) state_d = st_fetch;
            st_execr:    state_d = st_aluwb;
            st_execi:    state_d = st_aluwb;
            st_utype:    state_d = st_aluwb;
            st_jalradr:  state_d = st_jump;
            st_jump:     state_d = st_aluwb;
            st_aluwb:    state_d = st_fetch;
            st_branch:   state_d = st_fetch;
            st_halt:     state_d = st_halt;
            default:     state_d = st_fetch;
        endcase
    end

    always_comb begin
        pcwrite_raw    = 1'b0;
        memwrite_raw   = 1'b0;
        irwrite_raw    = 1'b0;
        regwrite_raw   = 1'b0;
        ctrl.AdrSrc    = 1'b0;
        ctrl.ResultSrc = rs_aluout;
        ctrl.ALUSrcA   = sa_pc;
        ctrl.ALUSrcB   = sb_rs2;
        alu_op         = aluop_add;
        case (state_q)
            st_fetch: begin
                ctrl.ALUSrcB   = sb_four;
                ctrl.ResultSrc = rs_aluresult;
                irwrite_raw    = ctrl.MemReady;
                pcwrite_raw    = ctrl.MemReady;
            end
            st_decode: begin
                ctrl.ALUSrcA = sa_oldpc;
                ctrl.ALUSrcB = sb_imm;
            end
            st_memadr, st_jalradr: begin
                ctrl.ALUSrcA = sa_rs1;
                ctrl.ALUSrcB = sb_imm;
            end
            st_memread:  ctrl.AdrSrc = 1'b1;
            st_memwb: begin
                ctrl.ResultSrc = rs_data;
                regwrite_raw   = 1'b1;
            end
            st_memwrite: begin
                ctrl.AdrSrc  = 1'b1;
                memwrite_raw = 1'b1;
            end
            st_execr: begin
                ctrl.ALUSrcA = sa_rs1;
                alu_op       = aluop_funct;
            end
            st_execi: begin
                ctrl.ALUSrcA = sa_rs1;
                ctrl.ALUSrcB = sb_imm;
                alu_op       = aluop_funct;
            end
            st_utype: begin
                ctrl.ALUSrcA = ctrl.Op[5] ? sa_zero : sa_oldpc;
                ctrl.ALUSrcB = sb_imm;
            end
            // PC loads the target held in ALUOut while ALUOut captures OldPC+4 for the link.
            st_jump: begin
                ctrl.ALUSrcA = sa_oldpc;
                ctrl.ALUSrcB = sb_four;
                pcwrite_raw  = 1'b1;
            end
            st_aluwb:    regwrite_raw = 1'b1;
            st_branch: begin
                ctrl.ALUSrcA = sa_rs1;
                alu_op       = aluop_sub;
                pcwrite_raw  = branch_taken(ctrl.Funct3, ctrl.Zero, ctrl.Lt, ctrl.Ltu);
            end
            default: ;
        endcase
    end

    // Write strobes are suppressed combinationally so a reset cycle can never commit state.
    assign ctrl.PCWrite  = pcwrite_raw  && !reset;
    assign ctrl.MemWrite = memwrite_raw && !reset;
    assign ctrl.IRWrite  = irwrite_raw  && !reset;
    assign ctrl.RegWrite = regwrite_raw && !reset;

    assign ctrl.SrcExt = (state_q == st_fetch) ? se_none : src_ext_of(ctrl.Op, ctrl.Funct3);

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .Funct3     (ctrl.Funct3),
        .Funct7b5   (ctrl.Funct7b5),
        .Op5        (ctrl.Op[5]),
        .ALUControl (ctrl.ALUControl)
    );

endmodule
